// File: rtl/stopwatch_display_ctrl_pkg.sv
// Shared types and limits for the stopwatch display controller.
package stopwatch_display_ctrl_pkg;

    localparam int H_W  = 4;
    localparam int M_W  = 6;
    localparam int S_W  = 6;
    localparam int MS_W = 10;

    localparam logic [MS_W-1:0] MS_MAX = 10'd999;
    localparam logic [S_W-1:0]  S_MAX  = 6'd59;
    localparam logic [M_W-1:0]  M_MAX  = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPED,
        ST_LAP
    } state_t;

    typedef struct packed {
        logic [H_W-1:0]  h;
        logic [M_W-1:0]  m;
        logic [S_W-1:0]  s;
        logic [MS_W-1:0] ms;
    } hms_t;

endpackage

// File: rtl/stopwatch_display_ctrl_time_counter.sv
// Binary h:m:s.ms cascade counter; exposes its next value so callers
// can capture the count including this cycle's increment.
module time_counter_bcdless
    import stopwatch_display_ctrl_pkg::*;
#(
    parameter int HOURS_MAX = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output hms_t cnt_next,
    output logic wrap
);

    localparam logic [H_W-1:0] H_MAX = H_W'(HOURS_MAX);

    hms_t cnt_q;

    // >= keeps every field in range even from an unexpected value
    always_comb begin
        cnt_next = cnt_q;
        wrap     = 1'b0;
        if (clr) begin
            cnt_next = '0;
        end else if (inc) begin
            if (cnt_q.ms >= MS_MAX) begin
                cnt_next.ms = '0;
                if (cnt_q.s >= S_MAX) begin
                    cnt_next.s = '0;
                    if (cnt_q.m >= M_MAX) begin
                        cnt_next.m = '0;
                        if (cnt_q.h >= H_MAX) begin
                            cnt_next.h = '0;
                            wrap       = 1'b1;
                        end else begin
                            cnt_next.h = cnt_q.h + H_W'(1);
                        end
                    end else begin
                        cnt_next.m = cnt_q.m + M_W'(1);
                    end
                end else begin
                    cnt_next.s = cnt_q.s + S_W'(1);
                end
            end else begin
                cnt_next.ms = cnt_q.ms + MS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_next;
        end
    end

endmodule

// File: rtl/stopwatch_display_ctrl.sv
// Stopwatch sequencing FSM with frame-synchronous display registers
// that load only on the rising edge of vblank.
module stopwatch_display_ctrl
    import stopwatch_display_ctrl_pkg::*;
#(
    parameter int HOURS_MAX  = 9,
    parameter bit FRAME_SYNC = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick_1ms,
    input  logic            btn_start_stop,
    input  logic            btn_lap,
    input  logic            btn_clear,
    input  logic            vblank,
    output logic [H_W-1:0]  hours,
    output logic [M_W-1:0]  minutes,
    output logic [S_W-1:0]  seconds,
    output logic [MS_W-1:0] milliseconds,
    output logic            running,
    output logic            lap_active,
    output logic            overflow,
    output logic            display_update
);

    state_t state, state_n;
    logic   cnt_inc, cnt_clr, snap_load, wrap;
    logic   vblank_q, load;
    hms_t   live_n, snap_q, snap_n, disp_src;

    time_counter_bcdless #(.HOURS_MAX(HOURS_MAX)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (cnt_inc),
        .clr      (cnt_clr),
        .cnt_next (live_n),
        .wrap     (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Tick qualification uses the pre-transition state
    always_comb begin
        state_n   = state;
        cnt_clr   = btn_clear;
        cnt_inc   = 1'b0;
        snap_load = 1'b0;
        if (btn_clear) begin
            state_n = ST_IDLE;
        end else begin
            cnt_inc = tick_1ms && (state == ST_RUN || state == ST_LAP);
            unique case (state)
                ST_IDLE: begin
                    if (btn_start_stop) state_n = ST_RUN;
                end
                ST_RUN: begin
                    if (btn_start_stop) begin
                        state_n = ST_STOPPED;
                    end else if (btn_lap) begin
                        state_n   = ST_LAP;
                        snap_load = 1'b1;
                    end
                end
                ST_LAP: begin
                    if (btn_start_stop)  state_n = ST_STOPPED;
                    else if (btn_lap)    state_n = ST_RUN;
                end
                ST_STOPPED: begin
                    if (btn_start_stop) state_n = ST_RUN;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign snap_n   = cnt_clr ? '0 : (snap_load ? live_n : snap_q);
    assign disp_src = (state_n == ST_LAP) ? snap_n : live_n;
    assign load     = FRAME_SYNC ? (vblank & ~vblank_q) : 1'b1;

    assign running    = (state == ST_RUN) || (state == ST_LAP);
    assign lap_active = (state == ST_LAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank_q       <= 1'b0;
            snap_q         <= '0;
            overflow       <= 1'b0;
            display_update <= 1'b0;
            hours          <= '0;
            minutes        <= '0;
            seconds        <= '0;
            milliseconds   <= '0;
        end else begin
            vblank_q       <= vblank;
            snap_q         <= snap_n;
            display_update <= load;
            if (cnt_clr) begin
                overflow <= 1'b0;
            end else if (wrap) begin
                overflow <= 1'b1;
            end
            if (load) begin
                hours        <= disp_src.h;
                minutes      <= disp_src.m;
                seconds      <= disp_src.s;
                milliseconds <= disp_src.ms;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_display_ctrl.sv
// Directed scenario bench for stopwatch_display_ctrl.
module tb_stopwatch_display_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1ms = 1'b0;
    logic       btn_start_stop = 1'b0;
    logic       btn_lap = 1'b0;
    logic       btn_clear = 1'b0;
    logic       vblank = 1'b0;
    logic [3:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [9:0] milliseconds;
    logic       running;
    logic       lap_active;
    logic       overflow;
    logic       display_update;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_display_ctrl #(.HOURS_MAX(9), .FRAME_SYNC(1'b1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tick_1ms       (tick_1ms),
        .btn_start_stop (btn_start_stop),
        .btn_lap        (btn_lap),
        .btn_clear      (btn_clear),
        .vblank         (vblank),
        .hours          (hours),
        .minutes        (minutes),
        .seconds        (seconds),
        .milliseconds   (milliseconds),
        .running        (running),
        .lap_active     (lap_active),
        .overflow       (overflow),
        .display_update (display_update)
    );

    task automatic press(input logic s, input logic l, input logic c);
        btn_start_stop = s;
        btn_lap        = l;
        btn_clear      = c;
        @(negedge clk);
        btn_start_stop = 1'b0;
        btn_lap        = 1'b0;
        btn_clear      = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick_1ms = 1'b1;
        repeat (n) @(negedge clk);
        tick_1ms = 1'b0;
    endtask

    // Leaves the bench just after the load edge
    task automatic do_load();
        @(negedge clk);
        vblank = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        vblank = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({hours, minutes, seconds, milliseconds, running, lap_active,
             overflow, display_update} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs got %0d:%0d:%0d.%0d r%0b l%0b o%0b u%0b want all 0",
                     hours, minutes, seconds, milliseconds, running,
                     lap_active, overflow, display_update);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (display_update !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_update got %0b want 0", display_update);
        end
    endtask

    task automatic test_run_basic();
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL start_running got %0b want 1", running);
        end
        ticks(1500);
        do_load();
        checks++;
        if ({hours, minutes, seconds, milliseconds} !== {4'd0, 6'd0, 6'd1, 10'd500}
            || display_update !== 1'b1 || running !== 1'b1) begin
            errors++;
            $display("FAIL run_1500 got %0d:%0d:%0d.%0d u%0b r%0b want 0:0:1.500 u1 r1",
                     hours, minutes, seconds, milliseconds, display_update, running);
        end
        @(negedge clk);
        checks++;
        if (display_update !== 1'b0) begin
            errors++;
            $display("FAIL update_one_cycle got %0b want 0", display_update);
        end
    endtask

    task automatic test_no_edge();
        int n;
        ticks(10);
        checks++;
        if ({hours, minutes, seconds, milliseconds} !== {4'd0, 6'd0, 6'd1, 10'd500}
            || display_update !== 1'b0) begin
            errors++;
            $display("FAIL hold_no_vblank got %0d:%0d:%0d.%0d u%0b want 0:0:1.500 u0",
                     hours, minutes, seconds, milliseconds, display_update);
        end
        n = 0;
        vblank = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (display_update === 1'b1) n++;
        end
        vblank = 1'b0;
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL vblank_held_loads got %0d want 1", n);
        end
        checks++;
        if ({hours, minutes, seconds, milliseconds} !== {4'd0, 6'd0, 6'd1, 10'd510}) begin
            errors++;
            $display("FAIL held_value got %0d:%0d:%0d.%0d want 0:0:1.510",
                     hours, minutes, seconds, milliseconds);
        end
    endtask

    task automatic test_lap();
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        ticks(2345);
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (lap_active !== 1'b1) begin
            errors++;
            $display("FAIL lap_enter got %0b want 1", lap_active);
        end
        ticks(3000);
        do_load();
        checks++;
        if ({hours, minutes, seconds, milliseconds} !== {4'd0, 6'd0, 6'd2, 10'd345}
            || lap_active !== 1'b1 || running !== 1'b1) begin
            errors++;
            $display("FAIL lap_snapshot got %0d:%0d:%0d.%0d l%0b r%0b want 0:0:2.345 l1 r1",
                     hours, minutes, seconds, milliseconds, lap_active, running);
        end
        press(1'b0, 1'b1, 1'b0);
        do_load();
        checks++;
        if ({hours, minutes, seconds, milliseconds} !== {4'd0, 6'd0, 6'd5, 10'd345}
            || lap_active !== 1'b0) begin
            errors++;
            $display("FAIL lap_release got %0d:%0d:%0d.%0d l%0b want 0:0:5.345 l0",
                     hours, minutes, seconds, milliseconds, lap_active);
        end
    endtask

    task automatic test_same_cycle();
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        ticks(7);
        tick_1ms = 1'b1;
        press(1'b1, 1'b0, 1'b0);
        tick_1ms = 1'b0;
        ticks(5);
        do_load();
        checks++;
        if (milliseconds !== 10'd8 || running !== 1'b0) begin
            errors++;
            $display("FAIL tick_with_stop got ms=%0d r%0b want ms=8 r0",
                     milliseconds, running);
        end
        press(1'b1, 1'b0, 1'b0);
        tick_1ms = 1'b1;
        press(1'b0, 1'b1, 1'b0);
        tick_1ms = 1'b0;
        ticks(4);
        do_load();
        checks++;
        if (milliseconds !== 10'd9 || lap_active !== 1'b1) begin
            errors++;
            $display("FAIL tick_with_lap got ms=%0d l%0b want ms=9 l1",
                     milliseconds, lap_active);
        end
        press(1'b0, 1'b1, 1'b0);
        tick_1ms = 1'b1;
        press(1'b0, 1'b0, 1'b1);
        tick_1ms = 1'b0;
        ticks(3);
        do_load();
        checks++;
        if ({hours, minutes, seconds, milliseconds} !== 26'd0 || running !== 1'b0) begin
            errors++;
            $display("FAIL tick_with_clear got %0d:%0d:%0d.%0d r%0b want 0:0:0.000 r0",
                     hours, minutes, seconds, milliseconds, running);
        end
    endtask

    task automatic test_wrap();
        press(1'b1, 1'b0, 1'b0);
        force dut.u_cnt.cnt_q = {4'd9, 6'd59, 6'd59, 10'd999};
        #1;
        release dut.u_cnt.cnt_q;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL pre_wrap_overflow got %0b want 0", overflow);
        end
        ticks(1);
        do_load();
        checks++;
        if ({hours, minutes, seconds, milliseconds} !== 26'd0
            || overflow !== 1'b1 || running !== 1'b1) begin
            errors++;
            $display("FAIL wrap got %0d:%0d:%0d.%0d o%0b r%0b want 0:0:0.000 o1 r1",
                     hours, minutes, seconds, milliseconds, overflow, running);
        end
        press(1'b0, 1'b0, 1'b1);
        do_load();
        checks++;
        if ({hours, minutes, seconds, milliseconds} !== 26'd0
            || overflow !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL wrap_clear got %0d:%0d:%0d.%0d o%0b r%0b want 0:0:0.000 o0 r0",
                     hours, minutes, seconds, milliseconds, overflow, running);
        end
    endtask

    task automatic test_async_reset();
        press(1'b1, 1'b0, 1'b0);
        ticks(50);
        do_load();
        checks++;
        if (milliseconds !== 10'd50) begin
            errors++;
            $display("FAIL pre_reset_count got ms=%0d want 50", milliseconds);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({hours, minutes, seconds, milliseconds, running, lap_active,
             overflow, display_update} !== 30'd0) begin
            errors++;
            $display("FAIL async_reset got %0d:%0d:%0d.%0d r%0b l%0b o%0b u%0b want all 0",
                     hours, minutes, seconds, milliseconds, running,
                     lap_active, overflow, display_update);
        end
        vblank = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (display_update !== 1'b1 || milliseconds !== 10'd0) begin
            errors++;
            $display("FAIL vblank_out_of_reset got u%0b ms=%0d want u1 ms=0",
                     display_update, milliseconds);
        end
        @(negedge clk);
        vblank = 1'b0;
        checks++;
        if (display_update !== 1'b0) begin
            errors++;
            $display("FAIL vblank_reset_single got %0b want 0", display_update);
        end
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (lap_active !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got l%0b r%0b want l0 r0",
                     lap_active, running);
        end
        press(1'b1, 1'b0, 1'b0);
        ticks(2);
        do_load();
        checks++;
        if ({hours, minutes, seconds, milliseconds} !== {4'd0, 6'd0, 6'd0, 10'd2}) begin
            errors++;
            $display("FAIL restart_after_reset got %0d:%0d:%0d.%0d want 0:0:0.002",
                     hours, minutes, seconds, milliseconds);
        end
    endtask

    initial begin
        test_reset();
        test_run_basic();
        test_no_edge();
        test_lap();
        test_same_cycle();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
